fd_pipe_reg: RTL and testbench

//   F/D pipeline register between the fetch unit and the decode stage of the P7 MIPS pipeline.

---
 rtl/fd_pipe_reg.sv | 128 ++++++++++++
 tb/tb_fd_pipe_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fd_pipe_reg.sv
// ---------------------------------------------------------------------------
// fd_pipe_reg
//   F/D pipeline register of the P7 MIPS pipeline. It latches the fetched
//   PC and instruction each cycle, holds them on a decode stall, and squashes
//   the slot on an interrupt/exception request or an eret. A fetch address
//   error (AdEL) replaces the instruction with a nop and carries the
//   exception code. The delay-slot flag travels with the instruction so that
//   CP0 can set EPC/BD correctly.
//
// Ports
//   clk         in   1   clock, rising edge
//   reset       in   1   synchronous, active-high
//   req         in   1   interrupt/exception taken; flush to handler bubble
//   stall       in   1   hazard stall from decode; hold contents
//   eret_flush  in   1   eret in decode; squash the fetched slot
//   f_pc        in   32  PC of the instruction being fetched
//   f_instr     in   32  instruction word from instruction memory
//   f_is_bd     in   1   fetched instruction sits in a delay slot
//   d_pc        out  32  PC presented to decode
//   d_instr     out  32  instruction presented to decode (0 = nop)
//   d_exc_code  out  5   exception code carried with the instruction
//   d_is_bd     out  1   delay-slot flag for decode
//   d_valid     out  1   1 = real instruction, 0 = bubble
// ---------------------------------------------------------------------------
module fd_pipe_reg #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IMEM_LO    = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI    = 32'h0000_6ffc,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        stall,
    input  logic        eret_flush,
    input  logic [31:0] f_pc,
    input  logic [31:0] f_instr,
    input  logic        f_is_bd,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic [4:0]  d_exc_code,
    output logic        d_is_bd,
    output logic        d_valid
);

    // The slot is either holding a real instruction or a bubble; this state
    // register is the d_valid flag itself, so no extra storage is added.
    typedef enum logic [0:0] {
        ST_BUBBLE = 1'b0,
        ST_VALID  = 1'b1
    } slot_state_t;

    slot_state_t r_state;
    slot_state_t w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [4:0]  r_exc_code;
    logic        r_is_bd;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [4:0]  w_exc_code_nxt;
    logic        w_is_bd_nxt;
    logic        w_adel;

    // Unsigned 32-bit range and alignment check on the fetch address.
    assign w_adel = (f_pc[1:0] != 2'b00) || (f_pc < IMEM_LO) || (f_pc > IMEM_HI);

    // Next-state selection: req > stall > eret_flush > load.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_exc_code_nxt = r_exc_code;
        w_is_bd_nxt    = r_is_bd;

        if (req) begin
            // Handler bubble: the PC stays defined for the macroscopic PC view.
            w_state_nxt    = ST_BUBBLE;
            w_pc_nxt       = HANDLER_PC;
            w_instr_nxt    = 32'h0;
            w_exc_code_nxt = 5'd0;
            w_is_bd_nxt    = 1'b0;
        end else if (stall) begin
            // Hold everything; an AdEL on the stalled fetch is not recorded
            // because that fetch is re-presented after the stall.
            w_state_nxt = r_state;
        end else if (eret_flush) begin
            w_state_nxt    = ST_BUBBLE;
            w_pc_nxt       = f_pc;
            w_instr_nxt    = 32'h0;
            w_exc_code_nxt = 5'd0;
            w_is_bd_nxt    = 1'b0;
        end else begin
            // A faulting fetch is still a valid slot so the exception reaches CP0.
            w_state_nxt    = ST_VALID;
            w_pc_nxt       = f_pc;
            w_instr_nxt    = w_adel ? 32'h0 : f_instr;
            w_exc_code_nxt = w_adel ? EXC_ADEL : 5'd0;
            w_is_bd_nxt    = f_is_bd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_BUBBLE;
            r_pc       <= PC_RESET;
            r_instr    <= 32'h0;
            r_exc_code <= 5'd0;
            r_is_bd    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_exc_code <= w_exc_code_nxt;
            r_is_bd    <= w_is_bd_nxt;
        end
    end

    assign d_pc       = r_pc;
    assign d_instr    = r_instr;
    assign d_exc_code = r_exc_code;
    assign d_is_bd    = r_is_bd;
    assign d_valid    = (r_state == ST_VALID);

endmodule

// File: tb/tb_fd_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_fd_pipe_reg
//   Directed vector table followed by a randomized run against a behavioural
//   model of the F/D register.
// ---------------------------------------------------------------------------
module tb_fd_pipe_reg;

    logic        clk;
    logic        reset;
    logic        req;
    logic        stall;
    logic        eret_flush;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        f_is_bd;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic [4:0]  d_exc_code;
    logic        d_is_bd;
    logic        d_valid;

    int total;
    int bad;

    fd_pipe_reg dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .stall      (stall),
        .eret_flush (eret_flush),
        .f_pc       (f_pc),
        .f_instr    (f_instr),
        .f_is_bd    (f_is_bd),
        .d_pc       (d_pc),
        .d_instr    (d_instr),
        .d_exc_code (d_exc_code),
        .d_is_bd    (d_is_bd),
        .d_valid    (d_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rq;
        logic        stl;
        logic        ert;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        bd;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic [4:0]  e_exc;
        logic        e_bd;
        logic        e_vld;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_ins;
    logic [4:0]  m_exc;
    logic        m_bd;
    logic        m_vld;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic rq, input logic stl, input logic ert,
                         input logic [31:0] pc, input logic [31:0] ins, input logic bd);
        reset      = rst;
        req        = rq;
        stall      = stl;
        eret_flush = ert;
        f_pc       = pc;
        f_instr    = ins;
        f_is_bd    = bd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                             input logic [4:0] e_exc, input logic e_bd, input logic e_vld);
        chk({tag, ".pc"},    d_pc,                e_pc);
        chk({tag, ".instr"}, d_instr,             e_ins);
        chk({tag, ".exc"},   {27'd0, d_exc_code}, {27'd0, e_exc});
        chk({tag, ".bd"},    {31'd0, d_is_bd},    {31'd0, e_bd});
        chk({tag, ".valid"}, {31'd0, d_valid},    {31'd0, e_vld});
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        case ($urandom_range(0, 5))
            0, 1: p = 32'h3000 + ($urandom_range(0, 16383) << 2);
            2:    p = (32'h3000 + ($urandom_range(0, 16383) << 2)) | $urandom_range(1, 3);
            3:    p = 32'h6ff8 + $urandom_range(0, 16);
            4:    p = 32'h2ff0 + $urandom_range(0, 32);
            default: p = $urandom;
        endcase
        return p;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1; req = 1'b0; stall = 1'b0; eret_flush = 1'b0;
        f_pc = 32'h0; f_instr = 32'h0; f_is_bd = 1'b0;

        //          rst   rq    stl   ert   pc            instr         bd      e_pc          e_instr       exc   bd    vld
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 32'h3000, 32'h0,        5'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_3004, 32'hffff_ffff, 1'b1, 32'h3000, 32'h0,        5'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3004, 32'h3c01_1234, 1'b1, 32'h3004, 32'h3c01_1234, 5'd0, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3002, 32'hdead_beef, 1'b0, 32'h3002, 32'h0,        5'd4, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_7000, 32'hdead_beef, 1'b1, 32'h7000, 32'h0,        5'd4, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_6ffc, 32'h1111_1111, 1'b0, 32'h6ffc, 32'h1111_1111, 5'd0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_2ffc, 32'h1234_5678, 1'b0, 32'h2ffc, 32'h0,        5'd4, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3008, 32'h2222_2222, 1'b0, 32'h3008, 32'h2222_2222, 5'd0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_300c, 32'haaaa_aaaa, 1'b1, 32'h3008, 32'h2222_2222, 5'd0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3011, 32'hbbbb_bbbb, 1'b0, 32'h3008, 32'h2222_2222, 5'd0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3010, 32'hcccc_cccc, 1'b1, 32'h3008, 32'h2222_2222, 5'd0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3014, 32'h3333_3333, 1'b0, 32'h3014, 32'h3333_3333, 5'd0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_3018, 32'h4444_4444, 1'b1, 32'h4180, 32'h0,        5'd0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3018, 32'h4444_4444, 1'b1, 32'h3018, 32'h4444_4444, 5'd0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_301c, 32'h5555_5555, 1'b0, 32'h3018, 32'h4444_4444, 5'd0, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_300c, 32'h5555_5555, 1'b1, 32'h300c, 32'h0,        5'd0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3020, 32'h6666_6666, 1'b1, 32'h300c, 32'h0,        5'd0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3024, 32'h7777_7777, 1'b0, 32'h4180, 32'h0,        5'd0, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3028, 32'h8888_8888, 1'b1, 32'h3000, 32'h0,        5'd0, 1'b0, 1'b0};

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].rq, vecs[i].stl, vecs[i].ert,
                  vecs[i].pc, vecs[i].ins, vecs[i].bd);
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ins,
                      vecs[i].e_exc, vecs[i].e_bd, vecs[i].e_vld);
        end

        // Hand-written sequence: three stalls in a row on a bubble left by eret,
        // then a faulting fetch released from the stall.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3040, 32'h9999_9999, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3041 + k, 32'h9999_9999, 1'b1);
            check_all($sformatf("bstall%0d", k), 32'h3040, 32'h0, 5'd0, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3045, 32'h9999_9999, 1'b1);
        check_all("release_adel", 32'h3045, 32'h0, 5'd4, 1'b1, 1'b1);

        // Randomized run against the behavioural model.
        m_pc = d_pc; m_ins = d_instr; m_exc = d_exc_code; m_bd = d_is_bd; m_vld = d_valid;
        m_pc = 32'h3045; m_ins = 32'h0; m_exc = 5'd4; m_bd = 1'b1; m_vld = 1'b1;
        for (int n = 0; n < 400; n++) begin
            logic        r_rst, r_rq, r_stl, r_ert, r_bd, adel;
            logic [31:0] r_pc, r_ins;
            r_rst = ($urandom_range(0, 39) == 0);
            r_rq  = ($urandom_range(0, 9) == 0);
            r_stl = ($urandom_range(0, 3) == 0);
            r_ert = ($urandom_range(0, 7) == 0);
            r_pc  = rand_pc();
            r_ins = $urandom;
            r_bd  = $urandom_range(0, 1);
            drive(r_rst, r_rq, r_stl, r_ert, r_pc, r_ins, r_bd);

            adel = (r_pc % 4 != 0) || (r_pc < 32'h3000) || (r_pc > 32'h6ffc);
            if (r_rst) begin
                m_pc = 32'h3000; m_ins = 0; m_exc = 0; m_bd = 0; m_vld = 0;
            end else if (r_rq) begin
                m_pc = 32'h4180; m_ins = 0; m_exc = 0; m_bd = 0; m_vld = 0;
            end else if (r_stl) begin
                // contents unchanged
            end else if (r_ert) begin
                m_pc = r_pc; m_ins = 0; m_exc = 0; m_bd = 0; m_vld = 0;
            end else begin
                m_pc  = r_pc;
                m_ins = adel ? 32'h0 : r_ins;
                m_exc = adel ? 5'd4 : 5'd0;
                m_bd  = r_bd;
                m_vld = 1'b1;
            end
            check_all($sformatf("rnd%0d", n), m_pc, m_ins, m_exc, m_bd, m_vld);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
